// File: rtl/mem_arbiter.sv
// Shares the single-ported RAM between instruction fetch and data load/store.
// One access at a time: IDLE picks a requester, ACCESS drives the RAM, RESP pulses the hit.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [31:0] ERR_WORD     = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        bus_error
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   store_q, store_d;
  logic          wr_q, wr_d;
  logic          gnt_q, gnt_d;      // 1 = data requester owns the access
  logic [RW-1:0] retry_q, retry_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   iload_q, iload_d;
  logic [31:0]   dload_q, dload_d;
  logic          berr_q, berr_d;
  logic          ihit_q, ihit_d;
  logic          dhit_q, dhit_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic          d_req_s;
  logic          starved_s;

  // Next-state, latching and registered-output decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    store_d   = store_q;
    wr_d      = wr_q;
    gnt_d     = gnt_q;
    retry_d   = retry_q;
    starve_d  = starve_q;
    iload_d   = iload_q;
    dload_d   = dload_q;
    berr_d    = berr_q;
    d_req_s   = dREN | dWEN;
    starved_s = (starve_q == SW'(STARVE_LIMIT)) && iREN;

    case (state_q)
      IDLE: begin
        if (d_req_s && !starved_s) begin
          gnt_d   = 1'b1;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
          retry_d = '0;
          state_d = ACCESS;
          if (!iREN) begin
            starve_d = '0;
          end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
          end else begin
            starve_d = starve_q;
          end
        end else if (iREN) begin
          gnt_d    = 1'b0;
          addr_d   = iaddr;
          wr_d     = 1'b0;
          retry_d  = '0;
          starve_d = '0;
          state_d  = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        case (ramstate)
          2'd2: begin
            if (!wr_q) begin
              if (gnt_q) dload_d = ramload;
              else       iload_d = ramload;
            end else begin
              dload_d = dload_q;
            end
            retry_d = '0;
            state_d = RESP;
          end
          2'd3: begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + RW'(1);
            end else begin
              // Give up: requester gets a recognisable poison word.
              if (gnt_q) dload_d = ERR_WORD;
              else       iload_d = ERR_WORD;
              berr_d  = 1'b1;
              retry_d = '0;
              state_d = RESP;
            end
          end
          default: state_d = ACCESS;
        endcase
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ihit_d = (state_d == RESP) && !gnt_d;
    dhit_d = (state_d == RESP) && gnt_d;
    ren_d  = (state_d == ACCESS) && !wr_d;
    wen_d  = (state_d == ACCESS) && wr_d;
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      addr_q   <= 32'd0;
      store_q  <= 32'd0;
      wr_q     <= 1'b0;
      gnt_q    <= 1'b0;
      retry_q  <= '0;
      starve_q <= '0;
      iload_q  <= 32'd0;
      dload_q  <= 32'd0;
      berr_q   <= 1'b0;
      ihit_q   <= 1'b0;
      dhit_q   <= 1'b0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
      gnt_q    <= gnt_d;
      retry_q  <= retry_d;
      starve_q <= starve_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
      berr_q   <= berr_d;
      ihit_q   <= ihit_d;
      dhit_q   <= dhit_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
    end
  end

  assign ihit      = ihit_q;
  assign dhit      = dhit_q;
  assign iload     = iload_q;
  assign dload     = dload_q;
  assign ramREN    = ren_q;
  assign ramWEN    = wen_q;
  assign ramaddr   = addr_q;
  assign ramstore  = store_q;
  assign bus_error = berr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: request batches are ordered by an
// abstract arbitration model, a RAM model replays per-access plans, a monitor checks hits.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = 32'd0;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = 32'd0;
  logic [31:0] dstore = 32'd0;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = 32'd0;
  logic [1:0]  ramstate = 2'd0;
  logic        bus_error;

  localparam logic [31:0] ERR_WORD = 32'hBAD1BAD1;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .bus_error(bus_error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_d;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          busy;
    int          errs;
  } req_t;

  typedef struct {
    bit          is_d;
    logic [31:0] val;
    bit          berr;
  } exp_t;

  req_t in_fq[$], in_dq[$];
  req_t drv_fq[$], drv_dq[$];
  req_t plan_q[$];
  exp_t exp_q[$];

  int          total = 0;
  int          bad = 0;
  int          m_starve = 0;
  bit          m_berr = 1'b0;
  logic [31:0] m_dload = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_f(input logic [31:0] a, input int b, input int e, input logic [31:0] rd);
    req_t r;
    r.is_d = 1'b0; r.ren = 1'b1; r.wen = 1'b0; r.addr = a; r.wdata = 32'd0;
    r.rdata = rd; r.busy = b; r.errs = e;
    in_fq.push_back(r);
  endtask

  task automatic add_d(input bit rn, input bit wn, input logic [31:0] a, input logic [31:0] wd,
                       input int b, input int e, input logic [31:0] rd);
    req_t r;
    r.is_d = 1'b1; r.ren = rn; r.wen = wn; r.addr = a; r.wdata = wd;
    r.rdata = rd; r.busy = b; r.errs = e;
    in_dq.push_back(r);
  endtask

  task automatic model_reset();
    m_starve = 0;
    m_berr   = 1'b0;
    m_dload  = 32'd0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ihit"},      {31'd0, ihit},      32'd0);
    chk({tag, "_dhit"},      {31'd0, dhit},      32'd0);
    chk({tag, "_ramREN"},    {31'd0, ramREN},    32'd0);
    chk({tag, "_ramWEN"},    {31'd0, ramWEN},    32'd0);
    chk({tag, "_ramaddr"},   ramaddr,            32'd0);
    chk({tag, "_ramstore"},  ramstore,           32'd0);
    chk({tag, "_iload"},     iload,              32'd0);
    chk({tag, "_dload"},     dload,              32'd0);
    chk({tag, "_bus_error"}, {31'd0, bus_error}, 32'd0);
  endtask

  // Order the batch by the arbitration rules, queue RAM plans and expected hits, then run it.
  task automatic run_batch();
    int   fi;
    int   di;
    int   cyc;
    bit   fp;
    req_t r;
    exp_t e;
    fi = 0;
    di = 0;
    while (fi < in_fq.size() || di < in_dq.size()) begin
      fp = (fi < in_fq.size());
      if (di < in_dq.size() && !(m_starve == 4 && fp)) begin
        r = in_dq[di];
        di++;
        m_starve = fp ? ((m_starve < 4) ? m_starve + 1 : 4) : 0;
      end else begin
        r = in_fq[fi];
        fi++;
        m_starve = 0;
      end
      if (r.errs > 3) begin
        m_berr = 1'b1;
        e.val  = ERR_WORD;
        if (r.is_d) m_dload = ERR_WORD;
      end else if (r.is_d) begin
        if (!r.wen) m_dload = r.rdata;
        e.val = m_dload;
      end else begin
        e.val = r.rdata;
      end
      e.is_d = r.is_d;
      e.berr = m_berr;
      plan_q.push_back(r);
      exp_q.push_back(e);
    end
    @(negedge CLK);
    drv_fq = in_fq;
    drv_dq = in_dq;
    in_fq.delete();
    in_dq.delete();
    cyc = 0;
    while ((exp_q.size() > 0 || drv_fq.size() > 0 || drv_dq.size() > 0) && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
    end
    if (cyc >= 3000) begin
      total++;
      bad++;
      $display("FAIL batch_timeout: %0d hits still outstanding, expected 0", exp_q.size());
      drv_fq.delete(); drv_dq.delete(); plan_q.delete(); exp_q.delete();
      nRST = 1'b0;
      model_reset();
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic random_batch(input int max_err);
    int nf;
    int nd;
    int k;
    nf = $urandom_range(0, 3);
    nd = $urandom_range(0, 6);
    if (nf + nd == 0) nf = 1;
    for (int i = 0; i < nf; i++) begin
      add_f($urandom() & 32'hFFFF_FFFC, $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0) ? max_err : $urandom_range(0, 2), $urandom());
    end
    for (int i = 0; i < nd; i++) begin
      k = $urandom_range(0, 2);
      add_d(k != 1, k != 0, $urandom(), $urandom(), $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0) ? max_err : $urandom_range(0, 2), $urandom());
    end
    run_batch();
  endtask

  // Requester driver: presents queue heads, drops/advances a request in its hit cycle.
  always @(negedge CLK) begin
    if (ihit && drv_fq.size() > 0) void'(drv_fq.pop_front());
    if (dhit && drv_dq.size() > 0) void'(drv_dq.pop_front());
    if (drv_fq.size() > 0) begin
      iREN  = 1'b1;
      iaddr = drv_fq[0].addr;
    end else begin
      iREN  = 1'b0;
      iaddr = $urandom();
    end
    if (drv_dq.size() > 0) begin
      dREN   = drv_dq[0].ren;
      dWEN   = drv_dq[0].wen;
      daddr  = drv_dq[0].addr;
      dstore = drv_dq[0].wdata;
    end else begin
      dREN   = 1'b0;
      dWEN   = 1'b0;
      daddr  = $urandom();
      dstore = $urandom();
    end
  end

  // RAM model: replays the plan of the next expected access, checking what the arbiter drives.
  req_t ram_cur;
  bit   ram_act = 1'b0;
  int   ram_step = 0;
  always @(posedge CLK) begin
    #1;
    if (!nRST) begin
      ram_act  = 1'b0;
      ramstate = 2'd0;
    end else if (ramREN || ramWEN) begin
      if (!ram_act) begin
        ram_act  = 1'b1;
        ram_step = 0;
        if (plan_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ram_access: addr=%h, expected no access", ramaddr);
          ram_cur.busy = 100000;
          ram_cur.errs = 0;
        end else begin
          ram_cur = plan_q.pop_front();
          chk("ramaddr", ramaddr, ram_cur.addr);
          chk("ramWEN", {31'd0, ramWEN}, {31'd0, ram_cur.is_d && ram_cur.wen});
          chk("ramREN", {31'd0, ramREN}, {31'd0, !(ram_cur.is_d && ram_cur.wen)});
          if (ram_cur.is_d && ram_cur.wen) chk("ramstore", ramstore, ram_cur.wdata);
        end
      end
      if (ram_step < ram_cur.busy) begin
        ramstate = 2'($urandom_range(0, 1));
        ramload  = $urandom();
      end else if (ram_step < ram_cur.busy + ram_cur.errs) begin
        ramstate = 2'd3;
        ramload  = $urandom();
      end else begin
        ramstate = 2'd2;
        ramload  = ram_cur.rdata;
      end
      ram_step++;
    end else begin
      ram_act  = 1'b0;
      ramstate = 2'd0;
      ramload  = $urandom();
    end
  end

  // Monitor: every hit pops the scoreboard and is compared against it.
  exp_t mon_e;
  always @(negedge CLK) begin
    if (nRST && (ihit || dhit)) begin
      chk("hit_exclusive", {31'd0, ihit & dhit}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_hit: ihit=%b dhit=%b, expected no hit", ihit, dhit);
      end else begin
        mon_e = exp_q.pop_front();
        chk("hit_is_data", {31'd0, dhit}, {31'd0, mon_e.is_d});
        if (mon_e.is_d) chk("dload", dload, mon_e.val);
        else            chk("iload", iload, mon_e.val);
        chk("bus_error", {31'd0, bus_error}, {31'd0, mon_e.berr});
      end
    end
  end

  int waitc;
  int hits;
  req_t rr;
  initial begin
    repeat (2) @(negedge CLK);
    chk_outputs_zero("reset");
    nRST = 1'b1;
    @(negedge CLK);

    add_f(32'h40, 2, 0, 32'h8C220004);
    run_batch();

    add_f(32'h44, 0, 0, 32'h01234567);
    add_d(1'b1, 1'b0, 32'h100, 32'd0, 1, 0, 32'hCAFEF00D);
    run_batch();

    add_d(1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 2, 0, 32'h55555555);
    run_batch();

    add_d(1'b1, 1'b1, 32'h204, 32'h0BADF00D, 0, 0, 32'h66666666);
    run_batch();

    add_f(32'h80, 0, 0, 32'h11112222);
    for (int i = 0; i < 6; i++) add_d(1'b1, 1'b0, 32'h300 + 32'(i * 4), 32'd0, 0, 0, $urandom());
    run_batch();

    add_d(1'b1, 1'b0, 32'h380, 32'd0, 1, 3, 32'h76543210);
    run_batch();

    // Reset while the RAM is still busy with a fetch.
    rr.is_d = 1'b0; rr.ren = 1'b1; rr.wen = 1'b0; rr.addr = 32'h500; rr.wdata = 32'd0;
    rr.rdata = 32'h12345678; rr.busy = 30; rr.errs = 0;
    plan_q.push_back(rr);
    @(negedge CLK);
    drv_fq.push_back(rr);
    waitc = 0;
    while (!ramREN && waitc < 20) begin
      @(negedge CLK);
      waitc++;
    end
    chk("reset_setup_ramREN", {31'd0, ramREN}, 32'd1);
    drv_fq.delete();
    nRST = 1'b0;
    #1;
    chk_outputs_zero("mid_reset");
    plan_q.delete();
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (ihit || dhit || ramREN || ramWEN) hits++;
    end
    chk("post_reset_quiet", hits, 32'd0);

    for (int i = 0; i < 15; i++) random_batch(3);

    add_d(1'b1, 1'b0, 32'h400, 32'd0, 0, 4, 32'h99999999);
    run_batch();
    add_f(32'h404, 0, 0, 32'h12121212);
    run_batch();

    for (int i = 0; i < 10; i++) random_batch(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
